// File: rtl/imm_materializer_if.sv
// Request/response bundle for imm_materializer: constant request in,
// encoded MOVZ/MOVK instruction words out.
interface imm_materializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_value;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  out_ctrl;
    logic        out_last;

    modport master (
        output in_valid, in_value, in_rd, out_ready,
        input  in_ready, out_valid, out_instr, out_ctrl, out_last
    );

    modport slave (
        input  in_valid, in_value, in_rd, out_ready,
        output in_ready, out_valid, out_instr, out_ctrl, out_last
    );
endinterface

// File: rtl/imm_materializer.sv
// Emits the shortest MOVZ/MOVK sequence that rebuilds a 64-bit constant,
// one instruction word per output handshake, lowest nonzero halfword first.
module imm_materializer #(
    parameter logic [8:0] MOVZ_OPC = 9'b110100101,
    parameter logic [8:0] MOVK_OPC = 9'b111100101
) (
    input logic          CLK,
    input logic          Reset,
    imm_materializer_if.slave bus
);

    typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t      state_r, state_nxt;
    logic [63:0] value_r, value_nxt;
    logic [4:0]  rd_r, rd_nxt;
    logic [3:0]  rem_r, rem_nxt;
    logic        valid_r, valid_nxt;
    logic [31:0] instr_r, instr_nxt;
    logic [2:0]  ctrl_r, ctrl_nxt;
    logic        last_r, last_nxt;
    logic [3:0]  nz_s;
    logic [3:0]  rem_s;
    logic [1:0]  hw_s;

    function automatic logic [3:0] nonzero_mask(input logic [63:0] v);
        nonzero_mask = {(v[63:48] != 16'h0000), (v[47:32] != 16'h0000),
                        (v[31:16] != 16'h0000), (v[15:0]  != 16'h0000)};
    endfunction

    // An empty mask maps to hw 0, which is exactly the MOVZ #0 case.
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        if (m[0])      lowest_set = 2'd0;
        else if (m[1]) lowest_set = 2'd1;
        else if (m[2]) lowest_set = 2'd2;
        else if (m[3]) lowest_set = 2'd3;
        else           lowest_set = 2'd0;
    endfunction

    function automatic logic [3:0] above_mask(input logic [1:0] hw);
        case (hw)
            2'd0:    above_mask = 4'b1110;
            2'd1:    above_mask = 4'b1100;
            2'd2:    above_mask = 4'b1000;
            2'd3:    above_mask = 4'b0000;
            default: above_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [15:0] halfword(input logic [63:0] v, input logic [1:0] hw);
        case (hw)
            2'd0:    halfword = v[15:0];
            2'd1:    halfword = v[31:16];
            2'd2:    halfword = v[47:32];
            2'd3:    halfword = v[63:48];
            default: halfword = 16'h0000;
        endcase
    endfunction

    function automatic logic [31:0] encode(input logic [8:0] opc, input logic [1:0] hw,
                                           input logic [15:0] imm, input logic [4:0] rd);
        encode = {opc, hw, imm, rd};
    endfunction

    assign bus.in_ready  = (state_r == IDLE) && !Reset;
    assign bus.out_valid = valid_r;
    assign bus.out_instr = instr_r;
    assign bus.out_ctrl  = ctrl_r;
    assign bus.out_last  = last_r;

    // Next-state and next-output decode; rem tracks nonzero halfwords still to emit.
    always_comb begin
        state_nxt = state_r;
        value_nxt = value_r;
        rd_nxt    = rd_r;
        rem_nxt   = rem_r;
        valid_nxt = valid_r;
        instr_nxt = instr_r;
        ctrl_nxt  = ctrl_r;
        last_nxt  = last_r;
        nz_s      = 4'b0000;
        rem_s     = 4'b0000;
        hw_s      = 2'd0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    nz_s      = nonzero_mask(bus.in_value);
                    hw_s      = lowest_set(nz_s);
                    rem_s     = nz_s & above_mask(hw_s);
                    value_nxt = bus.in_value;
                    rd_nxt    = bus.in_rd;
                    rem_nxt   = rem_s;
                    valid_nxt = 1'b1;
                    instr_nxt = encode(MOVZ_OPC, hw_s, halfword(bus.in_value, hw_s), bus.in_rd);
                    ctrl_nxt  = {1'b1, hw_s};
                    last_nxt  = (rem_s == 4'b0000);
                    state_nxt = EMIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (last_r) begin
                        state_nxt = IDLE;
                        rem_nxt   = 4'b0000;
                        valid_nxt = 1'b0;
                        instr_nxt = 32'h0000_0000;
                        ctrl_nxt  = 3'b000;
                        last_nxt  = 1'b0;
                    end else begin
                        hw_s      = lowest_set(rem_r);
                        rem_s     = rem_r & above_mask(hw_s);
                        rem_nxt   = rem_s;
                        instr_nxt = encode(MOVK_OPC, hw_s, halfword(value_r, hw_s), rd_r);
                        ctrl_nxt  = {1'b1, hw_s};
                        last_nxt  = (rem_s == 4'b0000);
                        state_nxt = EMIT;
                    end
                end else begin
                    state_nxt = EMIT;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any sequence in progress.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= IDLE;
            value_r <= 64'h0;
            rd_r    <= 5'd0;
            rem_r   <= 4'b0000;
            valid_r <= 1'b0;
            instr_r <= 32'h0000_0000;
            ctrl_r  <= 3'b000;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            value_r <= value_nxt;
            rd_r    <= rd_nxt;
            rem_r   <= rem_nxt;
            valid_r <= valid_nxt;
            instr_r <= instr_nxt;
            ctrl_r  <= ctrl_nxt;
            last_r  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_imm_materializer.sv
// Bench for imm_materializer: directed vectors, backpressure, reset
// mid-sequence and randomized constants against a halfword-scan model.
module tb_imm_materializer;

    localparam logic [8:0] MOVZ = 9'b110100101;
    localparam logic [8:0] MOVK = 9'b111100101;

    logic CLK;
    logic Reset;
    imm_materializer_if bus();

    imm_materializer dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_w [4];
    logic [2:0]  exp_c [4];
    int          exp_n;

    // Reference: scan halfwords low to high, keep nonzero ones; first is MOVZ.
    task automatic model_seq(input logic [63:0] v, input logic [4:0] rd);
        logic [63:0] h;
        logic [1:0]  hw;
        exp_n = 0;
        for (int k = 0; k < 4; k++) begin
            h  = (v >> (16 * k)) & 64'hFFFF;
            hw = 2'(k);
            if (h != 64'd0) begin
                exp_w[exp_n] = {(exp_n == 0) ? MOVZ : MOVK, hw, h[15:0], rd};
                exp_c[exp_n] = {1'b1, hw};
                exp_n++;
            end
        end
        if (exp_n == 0) begin
            exp_w[0] = {MOVZ, 2'b00, 16'h0000, rd};
            exp_c[0] = 3'b100;
            exp_n    = 1;
        end
    endtask

    // Called at a falling edge; request is presented for exactly one rising edge.
    task automatic send_req(input logic [63:0] v, input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_rd    = rd;
        @(negedge CLK);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_value = 64'h0; bus.in_rd = 5'd0; bus.out_ready = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h want 00000000", bus.out_instr); end
        n_checks++; if (bus.out_ctrl !== 3'b000) begin n_fail++; $display("FAIL reset_out_ctrl got %b want 000", bus.out_ctrl); end
        n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        Reset = 1'b0;
        @(negedge CLK);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    logic [63:0] tbl_v [4];
    logic [4:0]  tbl_rd [4];
    int          tbl_n [4];
    logic [31:0] tbl_w [4][4];

    task automatic test_directed;
        logic [31:0] w;
        tbl_v[0] = 64'h0;                   tbl_rd[0] = 5'd3;  tbl_n[0] = 1;
        tbl_v[1] = 64'h0000_0000_0000_1234; tbl_rd[1] = 5'd1;  tbl_n[1] = 1;
        tbl_v[2] = 64'hDEAD_0000_BEEF_0000; tbl_rd[2] = 5'd2;  tbl_n[2] = 2;
        tbl_v[3] = 64'hFFFF_FFFF_FFFF_FFFF; tbl_rd[3] = 5'd31; tbl_n[3] = 4;
        tbl_w[0] = '{32'hD2800003, 32'h0, 32'h0, 32'h0};
        tbl_w[1] = '{32'hD2824681, 32'h0, 32'h0, 32'h0};
        tbl_w[2] = '{32'hD2B7DDE2, 32'hF2FBD5A2, 32'h0, 32'h0};
        tbl_w[3] = '{32'hD29FFFFF, 32'hF2BFFFFF, 32'hF2DFFFFF, 32'hF2FFFFFF};
        bus.out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready got %b want 1", v, bus.in_ready); end
            send_req(tbl_v[v], tbl_rd[v]);
            for (int i = 0; i < tbl_n[v]; i++) begin
                w = tbl_w[v][i];
                n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_w%0d_valid got %b want 1", v, i, bus.out_valid); end
                n_checks++; if (bus.out_instr !== w) begin n_fail++; $display("FAIL dir%0d_w%0d_instr got %h want %h", v, i, bus.out_instr, w); end
                n_checks++; if (bus.out_ctrl !== {1'b1, w[22:21]}) begin n_fail++; $display("FAIL dir%0d_w%0d_ctrl got %b want %b", v, i, bus.out_ctrl, {1'b1, w[22:21]}); end
                n_checks++; if (bus.out_last !== (i == tbl_n[v] - 1)) begin n_fail++; $display("FAIL dir%0d_w%0d_last got %b want %b", v, i, bus.out_last, (i == tbl_n[v] - 1)); end
                @(negedge CLK);
            end
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_end_valid got %b want 0", v, bus.out_valid); end
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_end_in_ready got %b want 1", v, bus.in_ready); end
        end
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        send_req(64'hDEAD_0000_BEEF_0000, 5'd2);
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_valid got %b want 1", c, bus.out_valid); end
            n_checks++; if (bus.out_instr !== 32'hD2B7DDE2) begin n_fail++; $display("FAIL bp%0d_instr got %h want d2b7dde2", c, bus.out_instr); end
            n_checks++; if (bus.out_ctrl !== 3'b101 || bus.out_last !== 1'b0) begin n_fail++; $display("FAIL bp%0d_ctrl_last got %b/%b want 101/0", c, bus.out_ctrl, bus.out_last); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_in_ready got %b want 0", c, bus.in_ready); end
            bus.in_valid = 1'b1; bus.in_value = 64'h5; bus.in_rd = 5'd9;
            @(negedge CLK);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++; if (bus.out_instr !== 32'hD2B7DDE2) begin n_fail++; $display("FAIL bp_release_instr got %h want d2b7dde2", bus.out_instr); end
        @(negedge CLK);
        n_checks++; if (bus.out_instr !== 32'hF2FBD5A2 || bus.out_last !== 1'b1) begin n_fail++; $display("FAIL bp_w1 got %h/%b want f2fbd5a2/1", bus.out_instr, bus.out_last); end
        @(negedge CLK);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_end got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); end
        @(negedge CLK);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dropped_req got valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1'b1;
        send_req(64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
        n_checks++; if (bus.out_instr !== 32'hD29FFFFF) begin n_fail++; $display("FAIL rm_w0 got %h want d29fffff", bus.out_instr); end
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL rm_reset got valid %b instr %h want 0 00000000", bus.out_valid, bus.out_instr); end
        n_checks++; if (bus.out_ctrl !== 3'b000 || bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rm_reset_ctrl got %b/%b want 000/0", bus.out_ctrl, bus.out_last); end
        @(negedge CLK);
        n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_idle got ready %b valid %b want 1 0", bus.in_ready, bus.out_valid); end
        send_req(64'h5, 5'd7);
        n_checks++; if (bus.out_instr !== 32'hD28000A7 || bus.out_last !== 1'b1) begin n_fail++; $display("FAIL rm_new got %h/%b want d28000a7/1", bus.out_instr, bus.out_last); end
        n_checks++; if (bus.out_ctrl !== 3'b100) begin n_fail++; $display("FAIL rm_new_ctrl got %b want 100", bus.out_ctrl); end
        @(negedge CLK);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_new_end got %b want 0", bus.out_valid); end
    endtask

    // Back-to-back random constants with random consumer stalls.
    task automatic test_random;
        logic [63:0] v;
        logic [4:0]  rd;
        int          idx;
        for (int t = 0; t < 60; t++) begin
            v = 64'h0;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 1) == 1) v = v | (64'($urandom_range(1, 65535)) << (16 * k));
            rd = 5'($urandom_range(0, 31));
            model_seq(v, rd);
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_in_ready got %b want 1", t, bus.in_ready); end
            bus.out_ready = 1'($urandom_range(0, 1));
            send_req(v, rd);
            idx = 0;
            for (int cyc = 0; cyc < 40 && idx < exp_n; cyc++) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_instr !== exp_w[idx] || bus.out_ctrl !== exp_c[idx]
                    || bus.out_last !== (idx == exp_n - 1) || bus.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_w%0d got v%b %h c%b l%b r%b want v1 %h c%b l%b r0 (value %h)",
                             t, idx, bus.out_valid, bus.out_instr, bus.out_ctrl, bus.out_last, bus.in_ready,
                             exp_w[idx], exp_c[idx], (idx == exp_n - 1), v);
                end
                if (bus.out_ready) idx++;
                @(negedge CLK);
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            n_checks++; if (idx != exp_n) begin n_fail++; $display("FAIL rnd%0d_timeout got %0d words want %0d", t, idx, exp_n); end
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_end_valid got %b want 0", t, bus.out_valid); end
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
